fp_pow_int: RTL and testbench

FP_POW_INT -- requirements
Module: fp_pow_int

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp_mul.sv | 65 ++++++
 rtl/fp_pow_int.sv | 152 +++++++++++++++
 tb/tb_fp_pow_int.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// ============================================================================
// Module      : fp_pkg
// Description : Shared state encoding and IEEE-754 single-precision constants
//               for the fp_pow_int datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_INF  = 32'h7F80_0000;

endpackage

`default_nettype wire

// File: rtl/fp_mul.sv
// ============================================================================
// Module      : fp_mul
// Description : Combinational single-precision multiply, round-to-nearest-even,
//               denormals/underflow flushed to signed zero, overflow to infinity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mul
  import fp_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_p,
  output logic        o_ovf
);

  logic        w_sign;
  logic [7:0]  w_ea;
  logic [7:0]  w_eb;
  logic        w_zero_in;
  logic [47:0] w_prod;
  logic        w_norm;
  logic [22:0] w_frac;
  logic        w_guard;
  logic        w_sticky;
  logic        w_up;
  logic [23:0] w_rnd;
  logic [9:0]  w_esum;
  logic [7:0]  w_eres;

  assign w_sign    = i_a[31] ^ i_b[31];
  assign w_ea      = i_a[30:23];
  assign w_eb      = i_b[30:23];
  assign w_zero_in = (w_ea == 8'd0) || (w_eb == 8'd0);
  assign w_prod    = 48'({1'b1, i_a[22:0]}) * 48'({1'b1, i_b[22:0]});

  // Product of two [1,2) significands lies in [1,4); bit 47 selects the shift.
  assign w_norm   = w_prod[47];
  assign w_frac   = w_norm ? w_prod[46:24] : w_prod[45:23];
  assign w_guard  = w_norm ? w_prod[23]    : w_prod[22];
  assign w_sticky = w_norm ? |w_prod[22:0] : |w_prod[21:0];
  assign w_up     = w_guard & (w_sticky | w_frac[0]);
  assign w_rnd    = {1'b0, w_frac} + {23'd0, w_up};

  // Biased sum ea+eb still carries one extra bias of 127.
  assign w_esum = {2'b00, w_ea} + {2'b00, w_eb} + {9'd0, w_norm} + {9'd0, w_rnd[23]};
  assign w_eres = 8'(w_esum - 10'd127);

  always_comb begin
    o_ovf = 1'b0;
    o_p   = {w_sign, 31'd0};
    if (!w_zero_in) begin
      if (w_esum >= 10'd382) begin
        o_p   = {w_sign, FP_INF[30:0]};
        o_ovf = 1'b1;
      end else if (w_esum > 10'd127) begin
        o_p = {w_sign, w_eres, w_rnd[22:0]};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_pow_int.sv
// ============================================================================
// Module      : fp_pow_int
// Description : base^n for single-precision base and unsigned integer n using
//               right-to-left square-and-multiply, fixed ITER+1 cycle latency.
//               Optional macro FP_POW_SPECIAL_EN adds NaN/Inf operand handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_pow_int
  import fp_pkg::*;
#(
  parameter int ITER = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     base,
  input  logic [ITER-1:0] exp,
  output logic            busy,
  output logic            done,
  output logic [31:0]     out,
  output logic            ovf
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_acc;
  logic [31:0]     r_b;
  logic [ITER-1:0] r_exp;
  logic            r_sign;
  logic            r_ovf_acc;
  logic            r_b_sat;
`ifdef FP_POW_SPECIAL_EN
  logic            r_nz;
  logic            r_nan;
  logic            r_inf;
`endif

  logic [31:0] w_acc_prod;
  logic        w_acc_ovf;
  logic [31:0] w_sq_prod;
  logic        w_sq_ovf;
  logic [31:0] w_acc_next;
  logic        w_ovf_next;
  logic [31:0] w_res;
  logic        w_res_ovf;

  fp_mul u_mul_acc (
    .i_a   (r_acc),
    .i_b   (r_b),
    .o_p   (w_acc_prod),
    .o_ovf (w_acc_ovf)
  );

  fp_mul u_mul_sq (
    .i_a   (r_b),
    .i_b   (r_b),
    .o_p   (w_sq_prod),
    .o_ovf (w_sq_ovf)
  );

  // Once the accumulator saturates it is frozen at infinity.
  assign w_acc_next = (r_exp[0] && !r_ovf_acc) ? w_acc_prod : r_acc;
  assign w_ovf_next = r_ovf_acc | (r_exp[0] & w_acc_ovf);

  always_comb begin
    w_res     = {r_sign, (w_ovf_next ? FP_INF[30:0] : w_acc_next[30:0])};
    w_res_ovf = w_ovf_next;
`ifdef FP_POW_SPECIAL_EN
    if (r_nz && r_nan) begin
      w_res     = FP_QNAN;
      w_res_ovf = 1'b0;
    end else if (r_nz && r_inf) begin
      w_res     = {r_sign, FP_INF[30:0]};
      w_res_ovf = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_exp     <= '0;
      r_sign    <= 1'b0;
      r_ovf_acc <= 1'b0;
      r_b_sat   <= 1'b0;
`ifdef FP_POW_SPECIAL_EN
      r_nz      <= 1'b0;
      r_nan     <= 1'b0;
      r_inf     <= 1'b0;
`endif
      busy      <= 1'b0;
      done      <= 1'b0;
      out       <= 32'h0000_0000;
      ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_acc     <= FP_ONE;
            r_b       <= {1'b0, base[30:0]};
            r_exp     <= exp;
            r_sign    <= base[31] & exp[0];
            r_ovf_acc <= 1'b0;
            r_b_sat   <= 1'b0;
`ifdef FP_POW_SPECIAL_EN
            r_nz      <= |exp;
            r_nan     <= (base[30:23] == 8'hFF) && (base[22:0] != 23'd0);
            r_inf     <= (base[30:23] == 8'hFF) && (base[22:0] == 23'd0);
`endif
            busy      <= 1'b1;
          end
        end
        RUN: begin
          r_acc     <= w_acc_next;
          r_ovf_acc <= w_ovf_next;
          r_b       <= (r_b_sat || w_sq_ovf) ? FP_INF : w_sq_prod;
          r_b_sat   <= r_b_sat | w_sq_ovf;
          r_exp     <= r_exp >> 1;
          r_cnt     <= r_cnt + CW'(1);
          if (r_cnt == CW'(ITER - 1)) begin
            r_state <= FIN;
            done    <= 1'b1;
            out     <= w_res;
            ovf     <= w_res_ovf;
          end
        end
        FIN: begin
          r_state <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_pow_int.sv
// ============================================================================
// Module      : tb_fp_pow_int
// Description : Scoreboard bench for fp_pow_int with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_pow_int;

  localparam int ITER = 8;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          t0;
    string       name;
  } exp_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [31:0]     base  = 32'd0;
  logic [ITER-1:0] n_exp = '0;
  logic            busy;
  logic            done;
  logic [31:0]     out_w;
  logic            ovf;

  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  fp_pow_int #(.ITER(ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .base  (base),
    .exp   (n_exp),
    .busy  (busy),
    .done  (done),
    .out   (out_w),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 out=%h, required no done", out_w);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_out"}, out_w, e.res);
        chk({e.name, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
        chk({e.name, "_lat"}, 32'(cyc - e.t0), 32'(ITER + 1));
        chk({e.name, "_busy"}, {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic issue(input logic [31:0] b, input logic [ITER-1:0] n,
                       input logic [31:0] r, input logic ro, input string nm);
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_idle_timeout: got busy=1, required 0", nm);
    end
    base  = b;
    n_exp = n;
    start = 1'b1;
    sb.push_back('{res: r, ovf: ro, t0: cyc, name: nm});
    @(negedge clk);
    start = 1'b0;
    base  = 32'hDEAD_BEEF;
    n_exp = '1;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_done_timeout: got %0d pending, required 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic run1(input logic [31:0] b, input logic [ITER-1:0] n,
                      input logic [31:0] r, input logic ro, input string nm);
    issue(b, n, r, ro, nm);
    drain(nm);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out", out_w, 32'h0000_0000);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run1(32'h4120_0000, 8'd3,   32'h447A_0000, 1'b0, "ten_cubed");
    repeat (3) @(negedge clk);
    chk("hold_out", out_w, 32'h447A_0000);
    run1(32'hC000_0000, 8'd3,   32'hC100_0000, 1'b0, "neg2_pow3");
    run1(32'hC000_0000, 8'd4,   32'h4180_0000, 1'b0, "neg2_pow4");
    run1(32'h4000_0000, 8'd200, 32'h7F80_0000, 1'b1, "two_pow200");
    repeat (3) @(negedge clk);
    chk("hold_ovf", {31'd0, ovf}, 32'd1);
    run1(32'h3FC0_0000, 8'd2,   32'h4010_0000, 1'b0, "onehalf_sq");
    run1(32'h4000_0000, 8'd127, 32'h7F00_0000, 1'b0, "two_pow127");
    run1(32'h4000_0000, 8'd128, 32'h7F80_0000, 1'b1, "two_pow128");
    run1(32'h7FFF_FFFF, 8'd0,   32'h3F80_0000, 1'b0, "nan_pow0");
    run1(32'h0000_0000, 8'd0,   32'h3F80_0000, 1'b0, "zero_pow0");
    run1(32'h3F00_0000, 8'd3,   32'h3E00_0000, 1'b0, "half_pow3");
    run1(32'h0D80_0000, 8'd2,   32'h0000_0000, 1'b0, "tiny_sq_uflow");
    run1(32'h8D80_0000, 8'd3,   32'h8000_0000, 1'b0, "negtiny_cube");
    run1(32'h0040_0000, 8'd1,   32'h0000_0000, 1'b0, "denorm_flush");
    run1(32'h8040_0000, 8'd1,   32'h8000_0000, 1'b0, "negdenorm_flush");
    run1(32'h3F80_0808, 8'd2,   32'h3F80_1011, 1'b0, "round_up");
    run1(32'h3F80_0800, 8'd2,   32'h3F80_1000, 1'b0, "round_tie_even");
    run1(32'hBF80_0000, 8'd255, 32'hBF80_0000, 1'b0, "negone_pow255");
`ifdef FP_POW_SPECIAL_EN
    run1(32'h7FFF_FFFF, 8'd5,   32'h7FC0_0000, 1'b0, "sp_nan_pow5");
    run1(32'hFF80_0000, 8'd3,   32'hFF80_0000, 1'b0, "sp_neginf_pow3");
    run1(32'hFF80_0000, 8'd2,   32'h7F80_0000, 1'b0, "sp_neginf_pow2");
    run1(32'h8000_0000, 8'd3,   32'h8000_0000, 1'b0, "sp_negzero_pow3");
`endif

    // A second start while busy must be dropped.
    issue(32'h4120_0000, 8'd3, 32'h447A_0000, 1'b0, "busy_first");
    repeat (2) @(negedge clk);
    base  = 32'h4000_0000;
    n_exp = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("busy_first");
    repeat (12) @(negedge clk);
    chk("busy_ignored_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a computation.
    issue(32'h4120_0000, 8'd3, 32'h447A_0000, 1'b0, "aborted");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_out", out_w, 32'h0000_0000);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run1(32'hC000_0000, 8'd3, 32'hC100_0000, 1'b0, "after_rst");
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation time limit, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
